// File: rtl/fetch_prefetch_queue_pkg.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue_pkg
// Shared definitions for the instruction prefetch queue: the fetch FSM state
// encoding, the pipeline NOP pattern presented when no instruction is ready,
// and the width of one queue entry ({pc, inst}).
// ---------------------------------------------------------------------------
package fetch_prefetch_queue_pkg;

    // Fetch engine states: no request outstanding, waiting for a live
    // request, or waiting out a request whose data must be thrown away.
    typedef enum logic [1:0] {
        PFQ_IDLE = 2'd0,
        PFQ_WAIT = 2'd1,
        PFQ_DROP = 2'd2
    } pfq_state_e;

    // Instruction word the IF stage sees while the queue is empty.
    localparam logic [31:0] PIPE_NOP = 32'h8000_0000;

    // One queue entry holds the word address in the upper half and the
    // instruction in the lower half.
    localparam int PFQ_WIDTH = 64;

endpackage

// File: rtl/fetch_prefetch_queue_fifo.sv
// ---------------------------------------------------------------------------
// pfq_fifo
// Small synchronous FIFO used as the prefetch buffer. Head data is read
// combinationally; a pushed entry becomes visible the cycle after the push.
// Ports:
//   clk, rst         clock and synchronous active-high reset
//   clear            empty the FIFO (wins over push and pop)
//   push, push_data  write one entry at the tail
//   pop              remove the head entry (ignored while empty)
//   head_data        current head entry
//   count            number of occupied entries (0..DEPTH)
// ---------------------------------------------------------------------------
module pfq_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push;
    logic             do_pop;

    // Pointer and occupancy update. A pop on an empty FIFO is dropped, and a
    // push is refused only when full with no simultaneous pop, so the count
    // never leaves 0..DEPTH. Pointers wrap naturally because DEPTH is 2^AW.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != FULL_CNT) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage needs no reset; occupancy decides what is meaningful.
    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// ---------------------------------------------------------------------------
// fetch_prefetch_queue
// Fetches instructions from a handshaked instruction memory into a small
// queue and presents the head entry to the IF stage. A redirect flushes the
// queue and any in-flight fetch, then restarts fetching at redirect_pc.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   redirect, redirect_pc flush and restart fetch at a new word address
//   deq                   IF stage consumes the head entry this cycle
//   mem_req, mem_addr     memory request, held until mem_ack
//   mem_ack, mem_rdata    memory response for the outstanding request
//   inst_valid            head entry valid
//   inst_out              head instruction, PIPE_NOP while empty
//   pc_out, pc4_out       head word address and that address + 1
//   q_count               occupied queue entries
// ---------------------------------------------------------------------------
module fetch_prefetch_queue
    import fetch_prefetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'd0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     redirect,
    input  logic [31:0]              redirect_pc,
    input  logic                     deq,
    output logic                     mem_req,
    output logic [31:0]              mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic                     inst_valid,
    output logic [31:0]              inst_out,
    output logic [31:0]              pc_out,
    output logic [31:0]              pc4_out,
    output logic [$clog2(DEPTH):0]   q_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    pfq_state_e     state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic           mem_req_q, mem_req_d;
    logic [31:0]    mem_addr_q, mem_addr_d;

    logic           fifo_push;
    logic           fifo_pop;
    logic [CW-1:0]  fifo_count;
    logic [PFQ_WIDTH-1:0] fifo_head;

    // Fetch engine next state. Only one request is ever outstanding, and a
    // new one is issued only when a slot is free, so the eventual push can
    // never overflow. A redirect during a request that has not been acked
    // parks the engine in DROP so the stale response is swallowed.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        fifo_push  = 1'b0;
        case (state_q)
            PFQ_IDLE: begin
                if (!redirect && (fifo_count < DEPTH_CNT)) begin
                    state_d    = PFQ_WAIT;
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_pc_q;
                end
            end
            PFQ_WAIT: begin
                if (mem_ack) begin
                    state_d   = PFQ_IDLE;
                    mem_req_d = 1'b0;
                    if (!redirect) begin
                        fifo_push  = 1'b1;
                        fetch_pc_d = mem_addr_q + 32'd1;
                    end
                end else if (redirect) begin
                    state_d = PFQ_DROP;
                end
            end
            PFQ_DROP: begin
                if (mem_ack) begin
                    state_d   = PFQ_IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = PFQ_IDLE;
                mem_req_d = 1'b0;
            end
        endcase
        if (redirect) begin
            fetch_pc_d = redirect_pc;
        end
    end

    // Fetch engine registers, including the registered memory handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PFQ_IDLE;
            fetch_pc_q <= RESET_PC;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
        end
    end

    // Redirect flushes the queue; a consume in the same cycle is moot.
    assign fifo_pop = deq && !redirect;

    pfq_fifo #(
        .WIDTH (PFQ_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clear     (redirect),
        .push      (fifo_push),
        .push_data ({mem_addr_q, mem_rdata}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign q_count    = fifo_count;
    assign inst_valid = (fifo_count != '0);

    // Stale storage is never exposed: an empty queue shows a NOP at pc 0.
    assign inst_out = inst_valid ? fifo_head[31:0]  : PIPE_NOP;
    assign pc_out   = inst_valid ? fifo_head[63:32] : 32'd0;
    assign pc4_out  = pc_out + 32'd1;

endmodule
